// File: rtl/segre_main_memory_pkg.sv
// Shared sizes and the memory-operation size enum used by segre_main_memory.
package segre_main_memory_pkg;

    localparam int unsigned ADDR_SIZE        = 32;
    localparam int unsigned WORD_SIZE        = 32;
    localparam int unsigned DCACHE_LANE_SIZE = 128;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } memop_data_type_e;

endpackage

// File: rtl/segre_main_memory.sv
// segre_main_memory: byte-addressed little-endian backing memory with
// zero-latency writes and fixed-latency lane reads.
//
// Ports:
//   clk_i          clock, all state on rising edge
//   rsn_i          asynchronous active-low reset (memory array is not cleared)
//   rd_i           lane read request, accepted only when idle
//   rd_addr_i      read byte address (aligned down to LANE_BYTES)
//   wr_i           write request, committed on the same edge
//   wr_addr_i      write byte address (misaligned allowed, wraps)
//   wr_data_i      write data, right-aligned
//   wr_data_type_i write size: BYTE / HALF / WORD
//   data_rdy_o     one-cycle read data valid pulse
//   rd_data_o      returned lane, byte 0 in bits [7:0]; held between reads
//
// Optional build macro SEGRE_MM_ADDR_CHECK_EN: addresses >= MEM_BYTES are
// out of range (writes dropped, reads return 0xDEADBEEF words). Without it
// every address wraps modulo MEM_BYTES.
module segre_main_memory
    import segre_main_memory_pkg::*;
#(
    parameter int unsigned MEM_BYTES  = 65536,
    parameter int unsigned LATENCY    = 5,
    parameter int unsigned LANE_BYTES = DCACHE_LANE_SIZE / 8
) (
    input  logic                        clk_i,
    input  logic                        rsn_i,
    input  logic                        rd_i,
    input  logic [ADDR_SIZE-1:0]        rd_addr_i,
    input  logic                        wr_i,
    input  logic [ADDR_SIZE-1:0]        wr_addr_i,
    input  logic [WORD_SIZE-1:0]        wr_data_i,
    input  memop_data_type_e            wr_data_type_i,
    output logic                        data_rdy_o,
    output logic [DCACHE_LANE_SIZE-1:0] rd_data_o
);

    localparam int unsigned AW     = $clog2(MEM_BYTES);
    localparam int unsigned LANE_W = LANE_BYTES * 8;
    localparam int unsigned WB     = WORD_SIZE / 8;
    localparam int unsigned CW     = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    logic [7:0]        mem [MEM_BYTES];
    state_e            state;
    logic [CW-1:0]     cnt;
    logic [AW-1:0]     lane_idx;
    logic              wr_en_c;
    logic [WB-1:0]     wr_be_c;
    logic [AW-1:0]     wr_idx_c [WB];
    logic [LANE_W-1:0] lane_c;
    logic              unused_addr_bits;

    // Upper address bits only matter when the range check is built in.
    assign unused_addr_bits = ^{rd_addr_i, wr_addr_i};

`ifdef SEGRE_MM_ADDR_CHECK_EN
    localparam logic [DCACHE_LANE_SIZE-1:0] OOR_LANE = {(DCACHE_LANE_SIZE / 32){32'hDEADBEEF}};
    logic lane_oor;

    assign wr_en_c = wr_i && (wr_addr_i < ADDR_SIZE'(MEM_BYTES));
`else
    assign wr_en_c = wr_i;
`endif

    // Byte enables and wrapped byte indices of the current write.
    always_comb begin
        case (wr_data_type_i)
            BYTE:    wr_be_c = WB'(1);
            HALF:    wr_be_c = WB'(3);
            default: wr_be_c = '1;
        endcase
        for (int k = 0; k < WB; k++) begin
            wr_idx_c[k] = wr_addr_i[AW-1:0] + AW'(k);
        end
    end

    // Latched lane with the write of this edge forwarded, so a write on the
    // edge that enters RESP is part of the returned data.
    always_comb begin
        lane_c = '0;
        for (int j = 0; j < LANE_BYTES; j++) begin
            lane_c[j*8 +: 8] = mem[lane_idx + AW'(j)];
            for (int k = 0; k < WB; k++) begin
                if (wr_en_c && wr_be_c[k] && (wr_idx_c[k] == lane_idx + AW'(j))) begin
                    lane_c[j*8 +: 8] = wr_data_i[k*8 +: 8];
                end
            end
        end
    end

    // Memory array: no reset, writes suppressed while reset is asserted.
    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (rsn_i && wr_en_c) begin
            for (int k = 0; k < WB; k++) begin
                if (wr_be_c[k]) begin
                    mem[wr_idx_c[k]] <= wr_data_i[k*8 +: 8];
                end
            end
        end
    end

    // Read FSM. Every latency, including 1, passes through BUSY with the
    // counter at LATENCY-1 so data_rdy_o rises exactly LATENCY edges after
    // the request edge.
    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            state      <= IDLE;
            cnt        <= '0;
            data_rdy_o <= 1'b0;
            rd_data_o  <= '0;
            lane_idx   <= '0;
`ifdef SEGRE_MM_ADDR_CHECK_EN
            lane_oor   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (rd_i) begin
                        lane_idx <= rd_addr_i[AW-1:0] & ~AW'(LANE_BYTES - 1);
                        cnt      <= CW'(LATENCY - 1);
                        state    <= BUSY;
`ifdef SEGRE_MM_ADDR_CHECK_EN
                        lane_oor <= (rd_addr_i >= ADDR_SIZE'(MEM_BYTES));
`endif
                    end
                end
                BUSY: begin
                    if (cnt == '0) begin
                        state      <= RESP;
                        data_rdy_o <= 1'b1;
`ifdef SEGRE_MM_ADDR_CHECK_EN
                        rd_data_o  <= lane_oor ? OOR_LANE : DCACHE_LANE_SIZE'(lane_c);
`else
                        rd_data_o  <= DCACHE_LANE_SIZE'(lane_c);
`endif
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                RESP: begin
                    data_rdy_o <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_segre_main_memory.sv
// Self-checking bench for segre_main_memory against a byte-array model.
module tb_segre_main_memory;
    import segre_main_memory_pkg::*;

    localparam int unsigned MEM = 65536;
    localparam int          LAT = 5;
    localparam int unsigned LB  = 16;

    logic                        clk_i = 1'b0;
    logic                        rsn_i;
    logic                        rd_i;
    logic [ADDR_SIZE-1:0]        rd_addr_i;
    logic                        wr_i;
    logic [ADDR_SIZE-1:0]        wr_addr_i;
    logic [WORD_SIZE-1:0]        wr_data_i;
    memop_data_type_e            wr_data_type_i;
    logic                        data_rdy_o;
    logic [DCACHE_LANE_SIZE-1:0] rd_data_o;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] mem_ref [MEM];

    segre_main_memory #(.MEM_BYTES(MEM), .LATENCY(LAT), .LANE_BYTES(LB)) dut (
        .clk_i(clk_i), .rsn_i(rsn_i), .rd_i(rd_i), .rd_addr_i(rd_addr_i),
        .wr_i(wr_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
        .wr_data_type_i(wr_data_type_i), .data_rdy_o(data_rdy_o), .rd_data_o(rd_data_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic void model_write(input logic [31:0] a, input logic [31:0] d, input memop_data_type_e t);
        int n;
        n = (t == BYTE) ? 1 : (t == HALF) ? 2 : 4;
`ifdef SEGRE_MM_ADDR_CHECK_EN
        if (a >= 32'(MEM)) return;
`endif
        for (int k = 0; k < n; k++) mem_ref[(a + 32'(k)) % MEM] = d[8*k +: 8];
    endfunction

    function automatic logic [DCACHE_LANE_SIZE-1:0] model_lane(input logic [31:0] a);
        logic [DCACHE_LANE_SIZE-1:0] r;
        logic [31:0] base;
`ifdef SEGRE_MM_ADDR_CHECK_EN
        if (a >= 32'(MEM)) return {4{32'hDEADBEEF}};
`endif
        base = a & ~32'(LB - 1);
        for (int j = 0; j < int'(LB); j++) r[8*j +: 8] = mem_ref[(base + 32'(j)) % MEM];
        return r;
    endfunction

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input memop_data_type_e t);
        wr_i = 1'b1; wr_addr_i = a; wr_data_i = d; wr_data_type_i = t;
        @(negedge clk_i);
        wr_i = 1'b0;
        model_write(a, d, t);
    endtask

    // Issue one read; optionally write on edge wr_at after the request edge
    // (0 = same edge). Returns model expectation, observed lane, latency in
    // edges and data_rdy_o one cycle after the pulse.
    task automatic read_txn(input logic [31:0] ra, input int wr_at, input logic [31:0] wa,
                            input logic [31:0] wd, input memop_data_type_e wt,
                            output logic [DCACHE_LANE_SIZE-1:0] exp_lane,
                            output logic [DCACHE_LANE_SIZE-1:0] got,
                            output int lat, output logic rdy_after);
        rd_i = 1'b1; rd_addr_i = ra;
        if (wr_at == 0) begin wr_i = 1'b1; wr_addr_i = wa; wr_data_i = wd; wr_data_type_i = wt; end
        @(negedge clk_i);
        rd_i = 1'b0; rd_addr_i = $urandom;
        if (wr_at == 0) begin wr_i = 1'b0; model_write(wa, wd, wt); end
        lat = 0;
        while (!data_rdy_o && lat < 40) begin
            if (wr_at == lat + 1) begin wr_i = 1'b1; wr_addr_i = wa; wr_data_i = wd; wr_data_type_i = wt; end
            @(negedge clk_i);
            if (wr_at == lat + 1) begin wr_i = 1'b0; model_write(wa, wd, wt); end
            lat++;
        end
        exp_lane = model_lane(ra);
        got = rd_data_o;
        @(negedge clk_i);
        rdy_after = data_rdy_o;
    endtask

    task automatic test_reset();
        int pulses = 0;
        rsn_i = 1'b0; rd_i = 1'b1; rd_addr_i = 32'h40; wr_i = 1'b0;
        wr_addr_i = '0; wr_data_i = '0; wr_data_type_i = BYTE;
        @(negedge clk_i); @(negedge clk_i);
        n_checks++;
        if (data_rdy_o !== 1'b0) begin n_errors++; $display("FAIL reset_rdy: got %b expected 0", data_rdy_o); end
        n_checks++;
        if (rd_data_o !== '0) begin n_errors++; $display("FAIL reset_data: got %h expected 0", rd_data_o); end
        rd_i = 1'b0; rsn_i = 1'b1;
        for (int i = 0; i < 8; i++) begin @(negedge clk_i); if (data_rdy_o) pulses++; end
        n_checks++;
        if (pulses !== 0) begin n_errors++; $display("FAIL reset_no_pulse: got %0d pulses expected 0", pulses); end
    endtask

    task automatic prefill();
        for (int a = 0; a < 'h400; a += 4) do_write(32'(a), $urandom, WORD);
        for (int a = 'hFFF0; a < 'h10000; a += 4) do_write(32'(a), $urandom, WORD);
    endtask

    task automatic test_word_read();
        logic [DCACHE_LANE_SIZE-1:0] e, g; int lat; logic ra;
        do_write(32'h40, 32'h11223344, WORD);
        read_txn(32'h48, -1, 0, 0, BYTE, e, g, lat, ra);
        n_checks++;
        if (lat !== LAT) begin n_errors++; $display("FAIL word_latency: got %0d expected %0d", lat, LAT); end
        n_checks++;
        if (g[31:0] !== 32'h11223344) begin n_errors++; $display("FAIL word_bytes: got %h expected 11223344", g[31:0]); end
        n_checks++;
        if (g !== e) begin n_errors++; $display("FAIL word_lane: got %h expected %h", g, e); end
        n_checks++;
        if (ra !== 1'b0) begin n_errors++; $display("FAIL word_pulse_width: rdy after pulse %b expected 0", ra); end
    endtask

    task automatic test_byte_half();
        logic [DCACHE_LANE_SIZE-1:0] e, g; int lat; logic ra;
        do_write(32'h40, 32'h0, WORD);
        do_write(32'h41, 32'hAA, BYTE);
        do_write(32'h43, 32'hBEEF, HALF);
        read_txn(32'h40, -1, 0, 0, BYTE, e, g, lat, ra);
        n_checks++;
        if (g[31:0] !== 32'hEF00AA00) begin n_errors++; $display("FAIL bh_word0: got %h expected ef00aa00", g[31:0]); end
        n_checks++;
        if (g[39:32] !== 8'hBE) begin n_errors++; $display("FAIL bh_word1_b0: got %h expected be", g[39:32]); end
        n_checks++;
        if (g !== e) begin n_errors++; $display("FAIL bh_lane: got %h expected %h", g, e); end
    endtask

    task automatic test_busy_ignore();
        int pulses = 0, k1 = -1, k2 = -1;
        logic [DCACHE_LANE_SIZE-1:0] l1 = '0, l2 = '0;
        rd_i = 1'b1; rd_addr_i = 32'h100;
        for (int k = 0; k < 24; k++) begin
            @(negedge clk_i);
            rd_addr_i = 32'h200;
            if (data_rdy_o) begin
                pulses++;
                if (pulses == 1) begin k1 = k; l1 = rd_data_o; end
                else if (pulses == 2) begin k2 = k; l2 = rd_data_o; rd_i = 1'b0; end
            end
        end
        rd_i = 1'b0;
        n_checks++;
        if (pulses !== 2) begin n_errors++; $display("FAIL busy_pulses: got %0d expected 2", pulses); end
        n_checks++;
        if (k1 !== LAT) begin n_errors++; $display("FAIL busy_first_time: got %0d expected %0d", k1, LAT); end
        n_checks++;
        if (k2 !== 2 * LAT + 2) begin n_errors++; $display("FAIL busy_second_time: got %0d expected %0d", k2, 2 * LAT + 2); end
        n_checks++;
        if (l1 !== model_lane(32'h100)) begin n_errors++; $display("FAIL busy_lane1: got %h expected %h", l1, model_lane(32'h100)); end
        n_checks++;
        if (l2 !== model_lane(32'h200)) begin n_errors++; $display("FAIL busy_lane2: got %h expected %h", l2, model_lane(32'h200)); end
    endtask

    task automatic test_write_during_busy();
        logic [DCACHE_LANE_SIZE-1:0] e, g; int lat; logic ra; logic [31:0] d;
        read_txn(32'h80, 2, 32'h84, 32'hCAFEF00D, WORD, e, g, lat, ra);
        n_checks++;
        if (g[63:32] !== 32'hCAFEF00D) begin n_errors++; $display("FAIL wbusy_word1: got %h expected cafef00d", g[63:32]); end
        n_checks++;
        if (g !== e) begin n_errors++; $display("FAIL wbusy_lane: got %h expected %h", g, e); end
        d = $urandom;
        read_txn(32'h80, LAT, 32'h88, d, WORD, e, g, lat, ra);
        n_checks++;
        if (g[95:64] !== d) begin n_errors++; $display("FAIL wresp_edge_word2: got %h expected %h", g[95:64], d); end
        n_checks++;
        if (g !== e) begin n_errors++; $display("FAIL wresp_edge_lane: got %h expected %h", g, e); end
        do_write(32'h80, ~d, WORD);
        @(negedge clk_i); @(negedge clk_i);
        n_checks++;
        if (rd_data_o !== e) begin n_errors++; $display("FAIL hold_data: got %h expected %h", rd_data_o, e); end
        d = $urandom;
        read_txn(32'hC0, 0, 32'hC5, d, HALF, e, g, lat, ra);
        n_checks++;
        if (g[55:40] !== d[15:0]) begin n_errors++; $display("FAIL same_edge_half: got %h expected %h", g[55:40], d[15:0]); end
        n_checks++;
        if (g !== e) begin n_errors++; $display("FAIL same_edge_lane: got %h expected %h", g, e); end
    endtask

    task automatic test_wrap();
        logic [DCACHE_LANE_SIZE-1:0] e, g; int lat; logic ra;
        do_write(32'hFFFE, 32'hA1B2C3D4, WORD);
        read_txn(32'hFFF4, -1, 0, 0, BYTE, e, g, lat, ra);
        n_checks++;
        if (g[127:112] !== 16'hC3D4) begin n_errors++; $display("FAIL wrap_top: got %h expected c3d4", g[127:112]); end
        n_checks++;
        if (g !== e) begin n_errors++; $display("FAIL wrap_top_lane: got %h expected %h", g, e); end
        read_txn(32'h0, -1, 0, 0, BYTE, e, g, lat, ra);
        n_checks++;
        if (g[15:0] !== 16'hA1B2) begin n_errors++; $display("FAIL wrap_bottom: got %h expected a1b2", g[15:0]); end
    endtask

    task automatic test_reset_mid_busy();
        logic [DCACHE_LANE_SIZE-1:0] pre, e, g; int lat, pulses = 0; logic ra;
        pre = model_lane(32'h300);
        rd_i = 1'b1; rd_addr_i = 32'h300;
        @(negedge clk_i); rd_i = 1'b0;
        @(negedge clk_i); @(negedge clk_i);
        rsn_i = 1'b0;
        #1;
        n_checks++;
        if (data_rdy_o !== 1'b0) begin n_errors++; $display("FAIL midrst_rdy: got %b expected 0", data_rdy_o); end
        n_checks++;
        if (rd_data_o !== '0) begin n_errors++; $display("FAIL midrst_data: got %h expected 0", rd_data_o); end
        wr_i = 1'b1; wr_addr_i = 32'h300; wr_data_i = 32'hFFFFFFFF; wr_data_type_i = WORD;
        @(negedge clk_i); @(negedge clk_i);
        wr_i = 1'b0; rsn_i = 1'b1;
        for (int i = 0; i < 10; i++) begin @(negedge clk_i); if (data_rdy_o) pulses++; end
        n_checks++;
        if (pulses !== 0) begin n_errors++; $display("FAIL midrst_aborted: got %0d pulses expected 0", pulses); end
        read_txn(32'h300, -1, 0, 0, BYTE, e, g, lat, ra);
        n_checks++;
        if (g !== pre) begin n_errors++; $display("FAIL midrst_contents: got %h expected %h", g, pre); end
        n_checks++;
        if (lat !== LAT) begin n_errors++; $display("FAIL midrst_latency: got %0d expected %0d", lat, LAT); end
    endtask

    task automatic test_addr_check();
        logic [DCACHE_LANE_SIZE-1:0] e, g, c; int lat; logic ra;
`ifdef SEGRE_MM_ADDR_CHECK_EN
        c = {4{32'hDEADBEEF}};
`else
        c = model_lane(32'h0);
`endif
        read_txn(32'(MEM), -1, 0, 0, BYTE, e, g, lat, ra);
        n_checks++;
        if (g !== c) begin n_errors++; $display("FAIL oor_read: got %h expected %h", g, c); end
        n_checks++;
        if (lat !== LAT) begin n_errors++; $display("FAIL oor_latency: got %0d expected %0d", lat, LAT); end
        do_write(32'(MEM) + 32'h4, $urandom, WORD);
        read_txn(32'h0, -1, 0, 0, BYTE, e, g, lat, ra);
        n_checks++;
        if (g !== e) begin n_errors++; $display("FAIL oor_write: got %h expected %h", g, e); end
    endtask

    task automatic test_random();
        logic [DCACHE_LANE_SIZE-1:0] e, g; int lat, wat; logic rdy; logic [31:0] a, wa;
        for (int it = 0; it < 40; it++) begin
            for (int w = 0; w < int'($urandom_range(0, 2)); w++) begin
                a = 32'($urandom_range(0, 'h3FF));
                if ($urandom_range(0, 3) == 0) a |= 32'($urandom_range(1, 'hFFFF)) << 16;
                do_write(a, $urandom, memop_data_type_e'(2'($urandom_range(0, 2))));
            end
            a = 32'($urandom_range(0, 'h3F0));
            if ($urandom_range(0, 3) == 0) a |= 32'($urandom_range(1, 'hFFFF)) << 16;
            wat = int'($urandom_range(0, LAT + 1)) - 1;
            wa = $urandom_range(0, 1) ? ((a & ~32'(LB - 1)) + 32'($urandom_range(0, 12))) : 32'($urandom_range(0, 'h3FF));
            read_txn(a, wat, wa, $urandom, memop_data_type_e'(2'($urandom_range(0, 2))), e, g, lat, rdy);
            n_checks++;
            if (lat !== LAT) begin n_errors++; $display("FAIL rnd_latency[%0d]: got %0d expected %0d", it, lat, LAT); end
            n_checks++;
            if (g !== e) begin n_errors++; $display("FAIL rnd_lane[%0d] addr %h: got %h expected %h", it, a, g, e); end
            n_checks++;
            if (rdy !== 1'b0) begin n_errors++; $display("FAIL rnd_pulse_width[%0d]: got %b expected 0", it, rdy); end
        end
    endtask

    initial begin
        test_reset();
        prefill();
        test_word_read();
        test_byte_half();
        test_busy_ignore();
        test_write_during_busy();
        test_wrap();
        test_reset_mid_busy();
        test_addr_check();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/segre_main_memory.md
SEGRE_MAIN_MEMORY -- requirements
Module: segre_main_memory

Interface
REQ-001 SHALL have parameter MEM_BYTES, default 65536, memory size in bytes (power of two).
REQ-002 SHALL have parameter LATENCY, default 5, read latency in cycles (legal 1..15).
REQ-003 SHALL have parameter LANE_BYTES, default DCACHE_LANE_SIZE/8, bytes per returned lane.
REQ-004 SHALL have one clock and an asynchronous active-low reset: clk_i  input  1  clock, all state on rising edge.
REQ-005 SHALL have rsn_i  input  1  asynchronous active-low reset.
REQ-006 SHALL have rd_i  input  1  lane read request.
REQ-007 SHALL have rd_addr_i  input  ADDR_SIZE  read byte address.
REQ-008 SHALL have wr_i  input  1  write request.
REQ-009 SHALL have wr_addr_i  input  ADDR_SIZE  write byte address.
REQ-010 SHALL have wr_data_i  input  WORD_SIZE  write data, right-aligned.
REQ-011 SHALL have wr_data_type_i  input  memop_data_type_e  write size: BYTE, HALF, WORD.
REQ-012 SHALL have data_rdy_o  output  1  read data valid pulse.
REQ-013 SHALL have rd_data_o  output  DCACHE_LANE_SIZE  read lane, byte 0 in bits [7:0].

Function
REQ-014 SHALL be a byte-addressed little-endian array of MEM_BYTES bytes, indexed by address modulo MEM_BYTES.
REQ-015 SHALL commit a write on the rising edge where wr_i=1, in any FSM state, with zero latency and no acknowledge.
REQ-016 SHALL write 1/2/4 bytes for BYTE/HALF/WORD at wr_addr_i, wr_addr_i+1, ... taken from wr_data_i[7:0], [15:8], ...; misaligned addresses allowed, byte index wraps modulo MEM_BYTES.
REQ-017 SHALL implement FSM IDLE -> BUSY -> RESP -> IDLE.
REQ-018 SHALL in IDLE with rd_i=1 latch rd_addr_i aligned down to LANE_BYTES, load the latency counter with LATENCY-1, go BUSY (LATENCY=1: go directly RESP).
REQ-019 SHALL in BUSY decrement the counter each cycle and go RESP when it reaches 0.
REQ-020 SHALL in RESP drive data_rdy_o=1 for exactly one cycle with rd_data_o holding the latched lane, then go IDLE.
REQ-021 SHALL give read latency: rd_i sampled at edge N -> data_rdy_o high during cycle after edge N+LATENCY.
REQ-022 SHALL return lane contents including all writes committed at or before the edge entering RESP (write in same edge as RESP entry visible).
REQ-023 SHALL ignore rd_i in BUSY and RESP; rd_addr_i changes there have no effect.
REQ-024 SHALL accept a new read in the first IDLE cycle after RESP if rd_i=1 (requester drops rd_i on data_rdy_o to avoid a duplicate read).
REQ-025 SHALL accept simultaneous rd_i and wr_i in IDLE; the read observes the write if same lane.
REQ-026 SHALL hold rd_data_o at last returned lane outside RESP; data valid only when data_rdy_o=1.

Reset
REQ-027 SHALL on rsn_i=0 force FSM IDLE, counter 0, data_rdy_o=0, rd_data_o=0 immediately, regardless of state.
REQ-028 SHALL abort an in-flight read on reset; no data_rdy_o pulse for it afterwards.
REQ-029 SHALL NOT clear the memory array on reset; writes during reset ignored.

Configuration
REQ-030 SHALL with SEGRE_MM_ADDR_CHECK_EN defined treat addresses >= MEM_BYTES as out of range: writes dropped, read lane returned as all 0xDEADBEEF words, data_rdy_o timing unchanged.
REQ-031 SHALL without SEGRE_MM_ADDR_CHECK_EN wrap all addresses modulo MEM_BYTES per REQ-014.

Verification
REQ-032 SHALL cover: reset, WORD write 0x11223344 @0x40, read @0x48 -> data_rdy_o exactly 5 cycles after rd_i, lane bytes 0..3 = 44 33 22 11.
REQ-033 SHALL cover: BYTE 0xAA @0x41 and HALF 0xBEEF @0x43 over WORD 0 @0x40 -> lane word0 = 0xEF00AA00, word1 byte0 = 0xBE.
REQ-034 SHALL cover: rd_i @0x100 then rd_i @0x200 held during BUSY -> one pulse with 0x100 lane, second read accepted only after RESP.
REQ-035 SHALL cover: read @0x80, WORD write 0xCAFEF00D @0x84 during BUSY -> returned lane word1 = 0xCAFEF00D.
REQ-036 SHALL cover: rsn_i low mid-BUSY -> data_rdy_o stays 0, next read returns correct pre-reset memory contents.
REQ-037 SHALL cover: with SEGRE_MM_ADDR_CHECK_EN, read @MEM_BYTES -> all words 0xDEADBEEF; without, same read returns lane @0x0.
